// File: rtl/prio_dec_pkg.sv
// Shared constants and types for the priority encode/decode blocks.
// Index and counter widths are common to prio_dec and prio_enc.
package prio_dec_pkg;

    localparam int IDX_W = 8;
    localparam int CNT_W = 8;

    // Occupancy of the two-entry output buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/prio_dec_skid_buf.sv
// Two-entry output buffer (output register + skid register) with a registered in_ready.
// Handshake: a beat transfers on a rising edge where valid && ready; out_data holds while out_valid && !out_ready.
module skid_buf
    import prio_dec_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output occ_e         state_o
);

    occ_e         state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         emit;

    assign accept = in_valid_i && in_ready_q;
    assign emit   = out_valid_o && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d = OCC_ONE;
                    out_d   = in_data_i;
                end
            end
            OCC_ONE: begin
                if (accept && emit) begin
                    out_d = in_data_i;
                end else if (accept) begin
                    state_d = OCC_TWO;
                    skid_d  = in_data_i;
                end else if (emit) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // in_ready is low here, so only the skid entry can advance.
                if (emit) begin
                    state_d = OCC_ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
        in_ready_d = (state_d != OCC_TWO);
    end

    always_comb begin
        out_valid_o = (state_q != OCC_EMPTY);
        in_ready_o  = in_ready_q;
        out_data_o  = out_q;
        state_o     = state_q;
    end

endmodule

// File: rtl/prio_dec.sv
// Bit-index decoder: turns an index into a one-hot vector and a thermometer mask,
// flags out-of-range indices and counts them; results pass through a 2-entry skid buffer.
module prio_dec
    import prio_dec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_onehot,
    output logic [WIDTH-1:0] out_mask,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int PW = 2 * WIDTH + 1;

    logic [WIDTH-1:0] dec_onehot;
    logic [WIDTH-1:0] dec_mask;
    logic             dec_err;
    int               idx_int;
    logic [PW-1:0]    out_data;
    logic             accept;
    occ_e             buf_state;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        idx_int    = int'(in_idx);
        dec_err    = (idx_int >= WIDTH);
        dec_onehot = '0;
        dec_mask   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_onehot[i] = (idx_int == i);
            dec_mask[i]   = (i <= idx_int);
        end
        // Out-of-range: one-hot is already zero, mask saturates to all ones.
        if (dec_err) begin
            dec_mask = '1;
        end
    end

    skid_buf #(
        .W(PW)
    ) u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  ({dec_err, dec_mask, dec_onehot}),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .state_o    (buf_state)
    );

    assign {out_err, out_mask, out_onehot} = out_data;
    assign accept = in_valid && in_ready;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;

endmodule

// File: doc/prio_dec.md
PRIO_DEC -- requirements
Module: prio_dec

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the decoded vector width; legal range 2..256.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-004 in_valid  input  1  in_idx holds a bit index to decode.
REQ-005 in_ready  output  1  block can accept in_idx this cycle.
REQ-006 in_idx  input  8  bit index; same encoding prio_enc produces on msb.
REQ-007 out_valid  output  1  out_* fields hold a decoded result.
REQ-008 out_ready  input  1  consumer takes the result this cycle.
REQ-009 out_onehot  output  WIDTH  one-hot vector with bit in_idx set.
REQ-010 out_mask  output  WIDTH  thermometer mask: bits in_idx..0 set.
REQ-011 out_err  output  1  in_idx was >= WIDTH.
REQ-012 err_cnt  output  8  number of out-of-range indices accepted, saturating.

Function
REQ-013 A transfer SHALL occur on an input edge with in_valid && in_ready, and on an output edge with out_valid && out_ready.
REQ-014 For an in-range idx: out_onehot = 1 << idx; out_mask = (1 << (idx+1)) - 1 (all ones when idx = WIDTH-1); out_err = 0.
REQ-015 For idx >= WIDTH: out_onehot = 0; out_mask = all ones; out_err = 1.
REQ-016 Latency SHALL be 1 cycle: input accepted at edge N -> out_valid high after edge N, with that result, when the buffer was empty.
REQ-017 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-018 Buffering SHALL be 2 entries (output register + skid register); occupancy states EMPTY, ONE, TWO.
REQ-019 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without emit; ONE->EMPTY on emit without accept; ONE stays on accept+emit; TWO->ONE on emit; TWO SHALL accept nothing.
REQ-020 in_ready SHALL be a register output equal to (state != TWO); no combinational path from out_ready to in_ready.
REQ-021 Sustained in_valid with out_ready held high SHALL give one result per cycle.
REQ-022 out_* fields SHALL hold steady while out_valid && !out_ready.
REQ-023 On emit from TWO, the skid entry SHALL move to the output register in the same edge.
REQ-024 err_cnt SHALL increment on each accepted out-of-range idx and saturate at 255.
REQ-025 Behaviour with in_valid low SHALL be independent of in_idx.

Reset
REQ-026 While rst is high: state = EMPTY, out_valid = 0, in_ready = 0, out_onehot = 0, out_mask = 0, out_err = 0, err_cnt = 0.
REQ-027 in_ready SHALL rise at the first clk edge after rst falls.
REQ-028 Reset mid-transfer SHALL discard buffered results; nothing in flight SHALL appear after release.

Structure
REQ-029 The index width (8) and the err_cnt width SHALL be constants in the shared project include, also used by prio_enc.
REQ-030 The 2-entry buffer SHALL be a sub-module skid_buf, parameterised by payload width (2*WIDTH+1).
REQ-031 Decode logic SHALL be combinational before skid_buf; no per-bit state outside it.

Verification (WIDTH=16)
REQ-032 idx=0, out_ready=1 -> next cycle onehot=0x0001, mask=0x0001, err=0.
REQ-033 idx=15 then idx=7, back-to-back, out_ready=1 -> onehot 0x8000/mask 0xFFFF, then onehot 0x0080/mask 0x00FF, on consecutive cycles.
REQ-034 idx=20 -> onehot=0x0000, mask=0xFFFF, err=1, err_cnt=1; 300 out-of-range idx -> err_cnt=255.
REQ-035 out_ready=0, push idx 3,4,5 -> 3 and 4 accepted, in_ready low; raise out_ready -> 0x0008, 0x0010, 0x0020 in order.
REQ-036 rst pulse with 2 results buffered -> out_valid=0 immediately, err_cnt=0; no stale output after release.
REQ-037 Loopback prio_dec -> prio_enc over all idx 0..15 -> msb equals idx.
